// File: rtl/motion_sched.sv
// motion_sched: command FIFO plus sequencer feeding a six-axis pulse generator.
// Optional move watchdog is compiled in when MOTION_SCHED_TIMEOUT_EN is defined.
module motion_sched #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_motor,
  input  logic [9:0] cmd_pulses,
  input  logic       cmd_dir,
  input  logic [5:0] init_flag,
  input  logic       pg_busy,
  output logic [5:0] pg_motor,
  output logic [9:0] pg_pulse_num,
  output logic [5:0] pg_dir,
  output logic       done,
  output logic       cmd_err,
  output logic       ready_all
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {WAIT_INIT, IDLE, ISSUE, WAIT_BUSY, RUN, DONE} state_t;
  typedef struct packed {
    logic [2:0] motor;
    logic [9:0] pulses;
    logic       dir;
  } entry_t;

  state_t        state_q, state_d;
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [5:0]    pg_motor_q, pg_motor_d, pg_dir_q, pg_dir_d;
  logic [9:0]    pg_pulse_num_q, pg_pulse_num_d;
  logic          done_q, done_d, cmd_err_q, cmd_err_d, ready_all_q, ready_all_d;
  logic          accept, push, bad_cmd, pop, init_ok, abort, timeout_hit;
  entry_t        head;

  assign cmd_ready    = (count_q != CW'(FIFO_DEPTH));
  assign accept       = cmd_valid && cmd_ready;
  assign push         = accept && (cmd_motor <= 3'd5);
  assign bad_cmd      = accept && (cmd_motor > 3'd5);
  assign init_ok      = &init_flag;
  assign head         = mem_q[rd_ptr_q];
  assign pg_motor     = pg_motor_q;
  assign pg_pulse_num = pg_pulse_num_q;
  assign pg_dir       = pg_dir_q;
  assign done         = done_q;
  assign cmd_err      = cmd_err_q;
  assign ready_all    = ready_all_q;

`ifdef MOTION_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d     = '0;
    timeout_hit = 1'b0;
    if (state_q == WAIT_BUSY || state_q == RUN) begin
      timer_d     = timer_q + 1'b1;
      timeout_hit = (timer_q == TW'(TIMEOUT_CYC - 1));
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`else
  always_comb timeout_hit = 1'b0;
  // TIMEOUT_CYC only matters with the watchdog built in.
  if (TIMEOUT_CYC == 0) begin : g_timeout_unused
  end
`endif

  // An abort in ISSUE leaves the head in the FIFO; only an issued move is dropped.
  always_comb begin
    state_d        = state_q;
    pg_motor_d     = pg_motor_q;
    pg_pulse_num_d = pg_pulse_num_q;
    pg_dir_d       = pg_dir_q;
    done_d         = 1'b0;
    cmd_err_d      = bad_cmd;
    pop            = 1'b0;
    abort          = !init_ok && (state_q == IDLE || state_q == ISSUE ||
                                  state_q == WAIT_BUSY || state_q == RUN);
    if (abort) begin
      state_d        = WAIT_INIT;
      pg_motor_d     = '0;
      pg_pulse_num_d = '0;
      cmd_err_d      = 1'b1;
    end else begin
      case (state_q)
        WAIT_INIT: if (init_ok) state_d = IDLE;
        IDLE:      if (count_q != '0) state_d = ISSUE;
        ISSUE: begin
          pop = 1'b1;
          if (head.pulses == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d                = WAIT_BUSY;
            pg_motor_d             = 6'd1 << head.motor;
            pg_pulse_num_d         = head.pulses;
            pg_dir_d[head.motor]   = head.dir;
          end
        end
        WAIT_BUSY, RUN: begin
          if (timeout_hit) begin
            state_d        = IDLE;
            pg_motor_d     = '0;
            pg_pulse_num_d = '0;
            cmd_err_d      = 1'b1;
          end else if (state_q == WAIT_BUSY && pg_busy) begin
            state_d = RUN;
          end else if (state_q == RUN && !pg_busy) begin
            state_d        = DONE;
            pg_motor_d     = '0;
            pg_pulse_num_d = '0;
            done_d         = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = WAIT_INIT;
      endcase
    end
    ready_all_d = (state_d != WAIT_INIT);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = '{motor: cmd_motor, pulses: cmd_pulses, dir: cmd_dir};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q        <= WAIT_INIT;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      pg_motor_q     <= '0;
      pg_pulse_num_q <= '0;
      pg_dir_q       <= '0;
      done_q         <= 1'b0;
      cmd_err_q      <= 1'b0;
      ready_all_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      pg_motor_q     <= pg_motor_d;
      pg_pulse_num_q <= pg_pulse_num_d;
      pg_dir_q       <= pg_dir_d;
      done_q         <= done_d;
      cmd_err_q      <= cmd_err_d;
      ready_all_q    <= ready_all_d;
    end
  end
endmodule

// File: tb/tb_motion_sched.sv
// Directed testbench for motion_sched; expected values are hand-computed per step.
module tb_motion_sched;
  logic       sysclk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_motor;
  logic [9:0] cmd_pulses;
  logic       cmd_dir;
  logic [5:0] init_flag;
  logic       pg_busy;
  logic [5:0] pg_motor;
  logic [9:0] pg_pulse_num;
  logic [5:0] pg_dir;
  logic       done;
  logic       cmd_err;
  logic       ready_all;

  int checks = 0;
  int errors = 0;

  motion_sched #(.FIFO_DEPTH(4), .TIMEOUT_CYC(20)) dut (
    .sysclk(sysclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_motor(cmd_motor), .cmd_pulses(cmd_pulses), .cmd_dir(cmd_dir),
    .init_flag(init_flag), .pg_busy(pg_busy), .pg_motor(pg_motor),
    .pg_pulse_num(pg_pulse_num), .pg_dir(pg_dir), .done(done),
    .cmd_err(cmd_err), .ready_all(ready_all)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] m, input logic [9:0] p, input logic d);
    cmd_valid  = 1'b1;
    cmd_motor  = m;
    cmd_pulses = p;
    cmd_dir    = d;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_issue(input string tag, input logic [5:0] m, input logic [9:0] p,
                            input logic [5:0] d);
    int n;
    n = 0;
    while (pg_motor === 6'd0 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_motor"}, pg_motor, m);
    check({tag, "_pulses"}, pg_pulse_num, p);
    check({tag, "_dir"}, pg_dir, d);
  endtask

  task automatic end_move(input string tag, input int pre, input int hold);
    logic [5:0] m0;
    int unstable;
    int nd;
    m0 = pg_motor;
    unstable = 0;
    nd = 0;
    repeat (pre) begin
      tick();
      if (pg_motor !== m0) unstable++;
    end
    pg_busy = 1'b1;
    repeat (hold) begin
      tick();
      if (pg_motor !== m0) unstable++;
    end
    pg_busy = 1'b0;
    repeat (2) begin
      tick();
      if (done === 1'b1) nd++;
    end
    check({tag, "_stable"}, unstable, 0);
    check({tag, "_done_once"}, nd, 1);
    check({tag, "_idle_motor"}, pg_motor, 6'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      tick();
      if (pg_motor !== 6'd0 || done !== 1'b0) seen++;
    end
    check({tag, "_quiet"}, seen, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n;
    int nd;
    int seen;
    rst = 1'b1; cmd_valid = 1'b0; cmd_motor = '0; cmd_pulses = '0; cmd_dir = 1'b0;
    init_flag = 6'h00; pg_busy = 1'b0;
    tick(); tick();
    check("rst_ready", cmd_ready, 1);
    check("rst_motor", pg_motor, 0);
    check("rst_pulses", pg_pulse_num, 0);
    check("rst_dir", pg_dir, 0);
    check("rst_done", done, 0);
    check("rst_err", cmd_err, 0);
    check("rst_ready_all", ready_all, 0);
    rst = 1'b0;

    // Queue before calibration: nothing may issue.
    push(3'd1, 10'd5, 1'b0);
    push(3'd3, 10'd5, 1'b1);
    quiet("pre_init", 4);
    check("pre_init_ready_all", ready_all, 0);
    init_flag = 6'h3F;
    tick();
    check("init_ready_all", ready_all, 1);
    check("init_motor_idle", pg_motor, 0);
    wait_issue("m1", 6'b000010, 10'd5, 6'b000000);
    end_move("m1", 3, 50);
    wait_issue("m2", 6'b001000, 10'd5, 6'b001000);
    end_move("m2", 0, 2);

    // FIFO fill while a move is running.
    push(3'd2, 10'd10, 1'b1);
    wait_issue("a", 6'b000100, 10'd10, 6'b001100);
    pg_busy = 1'b1;
    tick();
    push(3'd0, 10'd1, 1'b0);
    push(3'd4, 10'd2, 1'b1);
    push(3'd5, 10'd3, 1'b0);
    check("fill3_ready", cmd_ready, 1);
    push(3'd1, 10'd4, 1'b1);
    check("full_ready", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_motor = 3'd2; cmd_pulses = 10'd6; cmd_dir = 1'b0;
    tick(); tick();
    check("full_ready_held", cmd_ready, 0);
    cmd_valid = 1'b0;
    end_move("a", 0, 1);
    wait_issue("b", 6'b000001, 10'd1, 6'b001100);
    end_move("b", 0, 1);
    wait_issue("c", 6'b010000, 10'd2, 6'b011100);
    end_move("c", 0, 1);
    wait_issue("d", 6'b100000, 10'd3, 6'b011100);
    end_move("d", 0, 1);
    wait_issue("e", 6'b000010, 10'd4, 6'b011110);
    end_move("e", 0, 1);
    quiet("fifth_dropped", 6);

    // Invalid motor index.
    cmd_valid = 1'b1; cmd_motor = 3'd6; cmd_pulses = 10'd3; cmd_dir = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("bad_err", cmd_err, 1);
    tick();
    check("bad_err_single", cmd_err, 0);
    quiet("bad_not_queued", 6);

    // Zero-pulse command completes without driving the generator.
    push(3'd4, 10'd0, 1'b1);
    nd = 0; seen = 0;
    repeat (6) begin
      tick();
      if (done === 1'b1) nd++;
      if (pg_motor !== 6'd0) seen++;
    end
    check("zero_done", nd, 1);
    check("zero_no_motor", seen, 0);
    check("zero_dir_kept", pg_dir, 6'b011110);

    // Calibration loss during RUN.
    push(3'd0, 10'd9, 1'b0);
    push(3'd5, 10'd8, 1'b1);
    wait_issue("g", 6'b000001, 10'd9, 6'b011110);
    pg_busy = 1'b1;
    tick();
    init_flag = 6'h3B;
    tick();
    check("drop_err", cmd_err, 1);
    check("drop_motor", pg_motor, 0);
    check("drop_pulses", pg_pulse_num, 0);
    check("drop_ready_all", ready_all, 0);
    pg_busy = 1'b0;
    tick();
    check("drop_err_single", cmd_err, 0);
    quiet("drop_wait_init", 4);
    init_flag = 6'h3F;
    wait_issue("h", 6'b100000, 10'd8, 6'b111110);
    end_move("h", 0, 1);
    quiet("h_discarded", 6);

    push(3'd2, 10'd3, 1'b0);
    wait_issue("t", 6'b000100, 10'd3, 6'b111010);
    pg_busy = 1'b1;
    n = 0; nd = 0;
`ifdef MOTION_SCHED_TIMEOUT_EN
    while (cmd_err !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (done === 1'b1) nd++;
    end
    check("timeout_cycles", n, 20);
    check("timeout_no_done", nd, 0);
    check("timeout_motor", pg_motor, 0);
    pg_busy = 1'b0;
    tick();
`else
    repeat (40) begin
      tick();
      if (cmd_err === 1'b1) n++;
    end
    check("no_timeout_err", n, 0);
    check("no_timeout_motor", pg_motor, 6'b000100);
    end_move("t", 0, 1);
`endif

    // Reset in the middle of a move flushes everything.
    push(3'd1, 10'd7, 1'b1);
    push(3'd3, 10'd2, 1'b0);
    wait_issue("r", 6'b000010, 10'd7, 6'b111010);
    pg_busy = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_motor", pg_motor, 0);
    check("mid_rst_pulses", pg_pulse_num, 0);
    check("mid_rst_dir", pg_dir, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", cmd_err, 0);
    check("mid_rst_ready_all", ready_all, 0);
    rst = 1'b0;
    pg_busy = 1'b0;
    nd = 0;
    repeat (8) begin
      tick();
      if (pg_motor !== 6'd0 || done !== 1'b0 || cmd_err !== 1'b0) nd++;
    end
    check("post_rst_flushed", nd, 0);
    check("post_rst_ready_all", ready_all, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
